// File: rtl/rc5_scan_pkg.sv
// Shared widths, scan-vector field map, FSM states and error codes for the
// rc5 validation scan receiver.
package rc5_scan_pkg;

  localparam int KEY_W        = 128;
  localparam int DATA_W       = 32;
  localparam int ROUNDS_W     = 5;
  localparam int DEF_TIMEOUT  = 1023;

  localparam int SCAN_IN_LEN  = KEY_W + DATA_W + ROUNDS_W + 3;
  localparam int SCAN_OUT_LEN = DATA_W + 1;

  // Stimulus vector layout, LSB upwards: key, d_in, num_rounds, three strobe bits.
  localparam int KEY_LSB  = 0;
  localparam int DIN_LSB  = KEY_LSB + KEY_W;
  localparam int RND_LSB  = DIN_LSB + DATA_W;
  localparam int LOAD_BIT = RND_LSB + ROUNDS_W;
  localparam int ENC_BIT  = LOAD_BIT + 1;
  localparam int DEC_BIT  = LOAD_BIT + 2;

  localparam logic [DATA_W-1:0] ERR_KEY_TIMEOUT = 32'hDEAD_0001;
  localparam logic [DATA_W-1:0] ERR_BOTH_START  = 32'hDEAD_0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_WAIT_KEY,
    ST_START,
    ST_WAIT_DONE,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/rc5_scan_ctrl_if.sv
// Core-side bundle between the scan receiver (master) and the rc5 core (slave).
interface rc5_scan_ctrl_if
  import rc5_scan_pkg::*;
();

  logic [KEY_W-1:0]    core_key;
  logic [DATA_W-1:0]   core_d_in;
  logic [ROUNDS_W-1:0] core_num_rounds;
  logic                core_load_key;
  logic                core_start_encrypt;
  logic                core_start_decrypt;
  logic                core_key_ready;
  logic [DATA_W-1:0]   core_d_out;
  logic                core_done;

  modport master (
    output core_key, core_d_in, core_num_rounds,
    output core_load_key, core_start_encrypt, core_start_decrypt,
    input  core_key_ready, core_d_out, core_done
  );

  modport slave (
    input  core_key, core_d_in, core_num_rounds,
    input  core_load_key, core_start_encrypt, core_start_decrypt,
    output core_key_ready, core_d_out, core_done
  );

endinterface

// File: rtl/rc5_scan_shreg.sv
// Serial-in shift register, MSB first, with a bit counter that saturates at
// WIDTH so "full" means at least one complete vector has been shifted in.
module rc5_scan_shreg #(
  parameter int WIDTH = 168
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             ser_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  assign full_o = (cnt_q == CNT_W'(WIDTH));
  assign data_o = data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (shift_en_i) begin
        data_q <= {data_q[WIDTH-2:0], ser_i};
      end
      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (shift_en_i && !full_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc5_scan_ctrl.sv
// Scan-driven validation controller: takes over the rc5 core inputs from a
// shifted-in vector, runs load/encrypt/decrypt and captures the result chain.
module rc5_scan_ctrl
  import rc5_scan_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic                scan_in,
  input  logic                begin_validate,
  output logic                scan_out,
  output logic                test_mode,
  input  logic [KEY_W-1:0]    func_key,
  input  logic [DATA_W-1:0]   func_d_in,
  input  logic [ROUNDS_W-1:0] func_num_rounds,
  input  logic                func_load_key,
  input  logic                func_start_encrypt,
  input  logic                func_start_decrypt,
  rc5_scan_ctrl_if.master     core
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic                    test_mode_q, test_mode_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [SCAN_OUT_LEN-1:0] cap_q, cap_d;
  logic                    bv_q;
  logic                    kr_q;

  logic [SCAN_IN_LEN-1:0]  vec;
  logic                    vec_full;
  logic                    cnt_clr;
  logic                    load_pulse, enc_pulse, dec_pulse;
  logic                    timed_out;

  rc5_scan_shreg #(.WIDTH(SCAN_IN_LEN)) u_in_chain (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (scan_en && (state_q == ST_IDLE)),
    .ser_i      (scan_in),
    .cnt_clr_i  (cnt_clr),
    .data_o     (vec),
    .full_o     (vec_full)
  );

  assign timed_out = (timer_q == TIMER_W'(TIMEOUT));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    test_mode_d = test_mode_q;
    cap_d       = cap_q;
    cnt_clr     = 1'b0;
    load_pulse  = 1'b0;
    enc_pulse   = 1'b0;
    dec_pulse   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (begin_validate && !bv_q) begin
          if (!vec_full) begin
            state_d = ST_RESULT;
            cap_d   = '0;
          end else begin
            test_mode_d = 1'b1;
            state_d     = vec[LOAD_BIT] ? ST_LOAD_KEY : ST_START;
          end
        end
      end
      ST_LOAD_KEY: begin
        load_pulse = 1'b1;
        state_d    = ST_WAIT_KEY;
      end
      ST_WAIT_KEY: begin
        if (core.core_key_ready && !kr_q) begin
          state_d = ST_START;
        end else if (timed_out) begin
          state_d = ST_RESULT;
          cap_d   = {1'b0, ERR_KEY_TIMEOUT};
        end
      end
      ST_START: begin
        if (vec[ENC_BIT] && vec[DEC_BIT]) begin
          state_d = ST_RESULT;
          cap_d   = {1'b0, ERR_BOTH_START};
        end else if (!vec[ENC_BIT] && !vec[DEC_BIT]) begin
          state_d = ST_RESULT;
          cap_d   = {1'b1, {DATA_W{1'b0}}};
        end else begin
          enc_pulse = vec[ENC_BIT];
          dec_pulse = vec[DEC_BIT];
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (core.core_done) begin
          state_d = ST_RESULT;
          cap_d   = {1'b1, core.core_d_out};
        end else if (timed_out) begin
          state_d = ST_RESULT;
          cap_d   = {1'b0, core.core_d_out};
        end
      end
      ST_RESULT: begin
        if (!begin_validate) begin
          state_d     = ST_IDLE;
          test_mode_d = 1'b0;
          cnt_clr     = 1'b1;
        end else if (scan_en) begin
          cap_d = {cap_q[SCAN_OUT_LEN-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping begin_validate mid-run abandons the run without a capture.
    if (!begin_validate &&
        (state_q inside {ST_LOAD_KEY, ST_WAIT_KEY, ST_START, ST_WAIT_DONE})) begin
      state_d     = ST_IDLE;
      test_mode_d = 1'b0;
      cap_d       = cap_q;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q inside {ST_WAIT_KEY, ST_WAIT_DONE}) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      test_mode_q <= 1'b0;
      timer_q     <= '0;
      cap_q       <= '0;
      bv_q        <= 1'b0;
      kr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      test_mode_q <= test_mode_d;
      timer_q     <= timer_d;
      cap_q       <= cap_d;
      bv_q        <= begin_validate;
      kr_q        <= core.core_key_ready;
    end
  end

  assign scan_out  = cap_q[SCAN_OUT_LEN-1];
  assign test_mode = test_mode_q;

  assign core.core_key           = test_mode_q ? vec[KEY_LSB +: KEY_W]    : func_key;
  assign core.core_d_in          = test_mode_q ? vec[DIN_LSB +: DATA_W]   : func_d_in;
  assign core.core_num_rounds    = test_mode_q ? vec[RND_LSB +: ROUNDS_W] : func_num_rounds;
  assign core.core_load_key      = test_mode_q ? load_pulse : func_load_key;
  assign core.core_start_encrypt = test_mode_q ? enc_pulse  : func_start_encrypt;
  assign core.core_start_decrypt = test_mode_q ? dec_pulse  : func_start_decrypt;

endmodule

// File: tb/tb_rc5_scan_ctrl.sv
// Directed bench for rc5_scan_ctrl with a behavioural rc5 core model:
// key_ready 200 cycles after load_key, done 40 cycles after start, d_out = ~d_in.
module tb_rc5_scan_ctrl;
  import rc5_scan_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                scan_en = 1'b0;
  logic                scan_in = 1'b0;
  logic                begin_validate = 1'b0;
  logic                scan_out;
  logic                test_mode;
  logic [KEY_W-1:0]    func_key = '0;
  logic [DATA_W-1:0]   func_d_in = '0;
  logic [ROUNDS_W-1:0] func_num_rounds = '0;
  logic                func_load_key = 1'b0;
  logic                func_start_encrypt = 1'b0;
  logic                func_start_decrypt = 1'b0;

  rc5_scan_ctrl_if core_if ();

  rc5_scan_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .scan_en            (scan_en),
    .scan_in            (scan_in),
    .begin_validate     (begin_validate),
    .scan_out           (scan_out),
    .test_mode          (test_mode),
    .func_key           (func_key),
    .func_d_in          (func_d_in),
    .func_num_rounds    (func_num_rounds),
    .func_load_key      (func_load_key),
    .func_start_encrypt (func_start_encrypt),
    .func_start_decrypt (func_start_decrypt),
    .core               (core_if)
  );

  always #5 clk = ~clk;

  // Behavioural rc5 core; also counts strobes seen from the controller.
  int kr_cnt, dn_cnt, n_load, n_enc, n_dec;
  bit hang_key = 1'b0;
  bit hang_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      core_if.core_key_ready <= 1'b0;
      core_if.core_done      <= 1'b0;
      core_if.core_d_out     <= '0;
      kr_cnt <= 0; dn_cnt <= 0; n_load <= 0; n_enc <= 0; n_dec <= 0;
    end else begin
      if (core_if.core_load_key) begin
        n_load <= n_load + 1;
        core_if.core_key_ready <= 1'b0;
        kr_cnt <= 200;
      end else if (kr_cnt > 0) begin
        kr_cnt <= kr_cnt - 1;
        if (kr_cnt == 1 && !hang_key) core_if.core_key_ready <= 1'b1;
      end
      if (core_if.core_start_encrypt || core_if.core_start_decrypt) begin
        n_enc <= n_enc + (core_if.core_start_encrypt ? 1 : 0);
        n_dec <= n_dec + (core_if.core_start_decrypt ? 1 : 0);
        core_if.core_done  <= 1'b0;
        core_if.core_d_out <= core_if.core_d_in ^ 32'hFFFF_FFFF;
        dn_cnt <= 40;
      end else if (dn_cnt > 0) begin
        dn_cnt <= dn_cnt - 1;
        if (dn_cnt == 1 && !hang_done) core_if.core_done <= 1'b1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [167:0] mk_vec(input bit dec, input bit enc, input bit load,
                                          input logic [4:0] rounds, input logic [31:0] din,
                                          input logic [127:0] key);
    return {dec, enc, load, rounds, din, key};
  endfunction

  task automatic do_reset();
    rst = 1'b1; scan_en = 1'b0; begin_validate = 1'b0;
    hang_key = 1'b0; hang_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic shift_vec(input logic [167:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      scan_en = 1'b1;
      scan_in = v[167-i];
      @(negedge clk);
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic read_chain(output logic [32:0] c);
    for (int i = 0; i < 33; i++) begin
      c[32-i] = scan_out;
      scan_en = 1'b1;
      @(negedge clk);
    end
    scan_en = 1'b0;
  endtask

  localparam logic [127:0] KEY  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] FKEY = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;

  logic [167:0] v;
  logic [32:0]  chain;

  initial begin
    // Reset: passthrough of functional pins, outputs cleared.
    func_key = FKEY; func_d_in = 32'hCAFE_F00D; func_num_rounds = 5'd12;
    func_load_key = 1'b1; func_start_decrypt = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_test_mode", test_mode, 1'b0);
    check("rst_scan_out", scan_out, 1'b0);
    check("rst_key_pass", core_if.core_key, FKEY);
    check("rst_din_pass", core_if.core_d_in, 32'hCAFE_F00D);
    check("rst_rounds_pass", core_if.core_num_rounds, 5'd12);
    check("rst_load_pass", core_if.core_load_key, 1'b1);
    check("rst_dec_pass", core_if.core_start_decrypt, 1'b1);
    func_load_key = 1'b0; func_start_decrypt = 1'b0;
    do_reset();

    // 1: load + encrypt.
    v = mk_vec(1'b0, 1'b1, 1'b1, 5'd31, 32'hD87F_AB42, KEY);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_test_mode", test_mode, 1'b1);
    check("t1_core_key", core_if.core_key, KEY);
    check("t1_core_din", core_if.core_d_in, 32'hD87F_AB42);
    check("t1_core_rounds", core_if.core_num_rounds, 5'd31);
    repeat (400) @(negedge clk);
    check("t1_n_load", n_load, 1);
    check("t1_n_enc", n_enc, 1);
    check("t1_n_dec", n_dec, 0);
    read_chain(chain);
    check("t1_chain", chain, {1'b1, 32'h2780_54BD});
    begin_validate = 1'b0;
    @(negedge clk);
    check("t1_idle_test_mode", test_mode, 1'b0);
    check("t1_idle_key_pass", core_if.core_key, FKEY);

    // 2: decrypt only, no load; extra leading bits exercise counter saturation.
    do_reset();
    v = mk_vec(1'b1, 1'b0, 1'b0, 5'd31, 32'hD87F_AB42, KEY);
    shift_vec({168{1'b1}}, 32);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (100) @(negedge clk);
    check("t2_n_load", n_load, 0);
    check("t2_n_enc", n_enc, 0);
    check("t2_n_dec", n_dec, 1);
    read_chain(chain);
    check("t2_chain", chain, {1'b1, 32'h2780_54BD});
    begin_validate = 1'b0;
    @(negedge clk);

    // 3: short vector.
    do_reset();
    shift_vec(v, 100);
    begin_validate = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_test_mode", test_mode, 1'b0);
    check("t3_n_dec", n_dec, 0);
    read_chain(chain);
    check("t3_chain", chain, 33'h0);
    begin_validate = 1'b0;
    @(negedge clk);

    // 4: done never arrives -> WAIT_DONE timeout.
    do_reset();
    hang_done = 1'b1;
    v = mk_vec(1'b0, 1'b1, 1'b0, 5'd12, 32'h1234_5678, KEY);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (1200) @(negedge clk);
    check("t4_n_enc", n_enc, 1);
    check("t4_test_mode", test_mode, 1'b1);
    read_chain(chain);
    check("t4_chain", chain, {1'b0, 32'hEDCB_A987});
    begin_validate = 1'b0;
    @(negedge clk);

    // 5: encrypt and decrypt both requested.
    do_reset();
    v = mk_vec(1'b1, 1'b1, 1'b0, 5'd12, 32'h1234_5678, KEY);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_n_starts", n_enc + n_dec, 0);
    read_chain(chain);
    check("t5_chain", chain, {1'b0, 32'hDEAD_0002});
    begin_validate = 1'b0;
    @(negedge clk);

    // 7: key_ready never rises -> WAIT_KEY timeout.
    do_reset();
    hang_key = 1'b1;
    v = mk_vec(1'b0, 1'b1, 1'b1, 5'd12, 32'h1234_5678, KEY);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (1300) @(negedge clk);
    check("t7_n_load", n_load, 1);
    check("t7_n_enc", n_enc, 0);
    read_chain(chain);
    check("t7_chain", chain, {1'b0, 32'hDEAD_0001});
    begin_validate = 1'b0;
    @(negedge clk);

    // 6: reset in WAIT_DONE restores passthrough and discards the vector.
    do_reset();
    hang_done = 1'b1;
    v = mk_vec(1'b0, 1'b1, 1'b0, 5'd7, 32'h0BAD_BEEF, KEY);
    shift_vec(v, 168);
    begin_validate = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_running", test_mode, 1'b1);
    func_start_encrypt = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_test_mode", test_mode, 1'b0);
    check("t6_rst_key_pass", core_if.core_key, FKEY);
    check("t6_rst_enc_pass", core_if.core_start_encrypt, 1'b1);
    begin_validate = 1'b0;
    func_start_encrypt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hang_done = 1'b0;
    repeat (2) @(negedge clk);
    begin_validate = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_fresh_test_mode", test_mode, 1'b0);
    read_chain(chain);
    check("t6_fresh_chain", chain, 33'h0);
    begin_validate = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
